// File: rtl/genius_pkg.sv
// genius_pkg: shared state encoding and sizing for the Genius game controller.
package genius_pkg;
   localparam int p_state = 3;
   localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
   typedef enum logic [p_state-1:0] {
      S_INIT   = 3'd0,
      S_SETUP  = 3'd1,
      S_FPGA   = 3'd2,
      S_USER   = 3'd3,
      S_CHECK  = 3'd4,
      S_NEXT   = 3'd5,
      S_RESULT = 3'd6
   } state_t;
endpackage

// File: rtl/genius_control_key_pulse.sv
// key_pulse: active-low key synchronizer with rising-edge pulse output.
// Debounce filter is built only when GENIUS_DEBOUNCE_EN is defined.
module key_pulse #(
   parameter int p_sync = 2
`ifdef GENIUS_DEBOUNCE_EN
   , parameter int p_debounce = 20
   , parameter int DEBOUNCE_CYCLES = 1000000
`endif
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic pulse
);
   logic [p_sync-1:0] sync;
   logic level, level_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sync <= '0;
      else sync <= {sync[p_sync-2:0], ~key_n};
`ifdef GENIUS_DEBOUNCE_EN
   logic [p_debounce-1:0] cnt;
   logic deb;
   // the debounced level only flips after DEBOUNCE_CYCLES consecutive differing samples
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt <= '0;
         deb <= 1'b0;
      end else if (sync[p_sync-1] == deb) cnt <= '0;
      else if (cnt == p_debounce'(DEBOUNCE_CYCLES - 1)) begin
         cnt <= '0;
         deb <= sync[p_sync-1];
      end else cnt <= cnt + 1'b1;
   assign level = deb;
`else
   assign level = sync[p_sync-1];
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         level_q <= 1'b0;
         pulse   <= 1'b0;
      end else begin
         level_q <= level;
         pulse   <= level & ~level_q;
      end
endmodule

// File: rtl/genius_control.sv
// genius_control: main FSM of the Genius memory game driving datapath resets/enables.
// Optional ENTER debounce via GENIUS_DEBOUNCE_EN.
module genius_control
   import genius_pkg::*;
#(
   parameter int p_sync = 2
`ifdef GENIUS_DEBOUNCE_EN
   , parameter int p_debounce = 20
   , parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
`endif
) (
   input  logic               CLOCK_50,
   input  logic               RESET_N,
   input  logic               ENTER,
   input  logic               end_FPGA,
   input  logic               end_User,
   input  logic               end_time,
   input  logic               win,
   input  logic               match,
   output logic               R1,
   output logic               R2,
   output logic               E1,
   output logic               E2,
   output logic               E3,
   output logic               E4,
   output logic               SEL,
   output logic [p_state-1:0] state_o
);
   state_t state, next;
   logic enter_p;
   key_pulse #(
      .p_sync(p_sync)
`ifdef GENIUS_DEBOUNCE_EN
      , .p_debounce(p_debounce)
      , .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`endif
   ) u_enter (
      .clk(CLOCK_50),
      .rst_n(RESET_N),
      .key_n(ENTER),
      .pulse(enter_p)
   );
   always_ff @(posedge CLOCK_50 or negedge RESET_N)
      if (!RESET_N) state <= S_INIT;
      else state <= next;
   always_comb begin
      next = S_INIT;
      case (state)
         S_INIT:   next = S_SETUP;
         S_SETUP:  next = enter_p ? S_FPGA : S_SETUP;
         S_FPGA:   next = end_FPGA ? S_USER : S_FPGA;
         S_USER:   next = end_time ? S_RESULT : enter_p ? S_CHECK : S_USER;
         S_CHECK:  next = !match ? S_RESULT : !end_User ? S_USER : win ? S_RESULT : S_NEXT;
         S_NEXT:   next = S_FPGA;
         S_RESULT: next = enter_p ? S_INIT : S_RESULT;
         default:  next = S_INIT;
      endcase
   end
   assign R1      = state == S_INIT;
   assign R2      = state inside {S_INIT, S_FPGA, S_NEXT};
   assign E1      = state == S_SETUP;
   assign E2      = state == S_USER;
   assign E3      = state == S_FPGA;
   assign E4      = state inside {S_CHECK, S_NEXT};
   assign SEL     = state == S_RESULT;
   assign state_o = state;
endmodule

// File: tb/tb_genius_control.sv
// tb_genius_control: directed self-checking bench for genius_control.
module tb_genius_control;
  logic CLOCK_50 = 1'b0;
  logic RESET_N = 1'b0;
  logic ENTER = 1'b1;
  logic end_FPGA = 1'b0, end_User = 1'b0, end_time = 1'b0, win = 1'b0, match = 1'b1;
  logic R1, R2, E1, E2, E3, E4, SEL;
  logic [2:0] state_o;
  int checks = 0;
  int errors = 0;
`ifdef GENIUS_DEBOUNCE_EN
  localparam int LAT = 12, SETTLE = 16;
`else
  localparam int LAT = 4, SETTLE = 5;
`endif
  always #5 CLOCK_50 = ~CLOCK_50;
`ifdef GENIUS_DEBOUNCE_EN
  genius_control #(.DEBOUNCE_CYCLES(8)) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .ENTER(ENTER),
    .end_FPGA(end_FPGA), .end_User(end_User), .end_time(end_time),
    .win(win), .match(match),
    .R1(R1), .R2(R2), .E1(E1), .E2(E2), .E3(E3), .E4(E4), .SEL(SEL),
    .state_o(state_o)
  );
`else
  genius_control dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .ENTER(ENTER),
    .end_FPGA(end_FPGA), .end_User(end_User), .end_time(end_time),
    .win(win), .match(match),
    .R1(R1), .R2(R2), .E1(E1), .E2(E2), .E3(E3), .E4(E4), .SEL(SEL),
    .state_o(state_o)
  );
`endif
  task automatic step;
    @(posedge CLOCK_50);
    #1;
  endtask
  task automatic settle;
    repeat (SETTLE) step;
  endtask
  task automatic wait_change(input logic [2:0] from, output int n);
    n = 0;
    while (state_o == from && n < 40) begin
      step;
      n++;
    end
  endtask
  task automatic restart;
    @(negedge CLOCK_50);
    RESET_N = 1'b0;
    #2;
    RESET_N = 1'b1;
    step;
  endtask
  task automatic go_user;
    int n;
    ENTER = 1'b0;
    wait_change(3'd1, n);
    ENTER = 1'b1;
    settle;
    end_FPGA = 1'b1;
    step;
    end_FPGA = 1'b0;
  endtask
  task automatic test_reset;
    #1;
    checks++;
    if (state_o !== 3'd0 || R1 !== 1'b1 || R2 !== 1'b1 || SEL !== 1'b0 || E1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got state=%0d R1=%b R2=%b SEL=%b E1=%b want state=0 R1=1 R2=1 SEL=0 E1=0", state_o, R1, R2, SEL, E1);
    end
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    step;
    checks++;
    if (state_o !== 3'd1 || E1 !== 1'b1 || R1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_to_setup: got state=%0d E1=%b R1=%b want state=1 E1=1 R1=0", state_o, E1, R1);
    end
  endtask
  task automatic test_ignore;
    end_FPGA = 1'b1; end_time = 1'b1; end_User = 1'b1; win = 1'b1; match = 1'b0;
    repeat (5) step;
    checks++;
    if (state_o !== 3'd1) begin
      errors++;
      $display("FAIL setup_ignores_flags: got state=%0d want 1", state_o);
    end
    end_FPGA = 1'b0; end_time = 1'b0; end_User = 1'b0; win = 1'b0; match = 1'b1;
  endtask
  task automatic test_win;
    int n;
    ENTER = 1'b0;
    wait_change(3'd1, n);
    checks++;
    if (state_o !== 3'd2 || E3 !== 1'b1 || R2 !== 1'b1 || E1 !== 1'b0) begin
      errors++;
      $display("FAIL setup_to_fpga: got state=%0d E3=%b R2=%b E1=%b want state=2 E3=1 R2=1 E1=0", state_o, E3, R2, E1);
    end
    ENTER = 1'b1;
    settle;
    checks++;
    if (state_o !== 3'd2) begin
      errors++;
      $display("FAIL fpga_waits: got state=%0d want 2", state_o);
    end
    end_FPGA = 1'b1;
    step;
    end_FPGA = 1'b0;
    checks++;
    if (state_o !== 3'd3 || E2 !== 1'b1 || E3 !== 1'b0) begin
      errors++;
      $display("FAIL fpga_to_user: got state=%0d E2=%b E3=%b want state=3 E2=1 E3=0", state_o, E2, E3);
    end
    match = 1'b1; end_User = 1'b1; win = 1'b1;
    ENTER = 1'b0;
    wait_change(3'd3, n);
    checks++;
    if (state_o !== 3'd4 || E4 !== 1'b1 || E2 !== 1'b0) begin
      errors++;
      $display("FAIL win_check: got state=%0d E4=%b E2=%b want state=4 E4=1 E2=0", state_o, E4, E2);
    end
    step;
    checks++;
    if (state_o !== 3'd6 || SEL !== 1'b1 || E4 !== 1'b0) begin
      errors++;
      $display("FAIL win_result: got state=%0d SEL=%b E4=%b want state=6 SEL=1 E4=0", state_o, SEL, E4);
    end
    ENTER = 1'b1;
    settle;
    end_User = 1'b0; win = 1'b0;
    checks++;
    if (state_o !== 3'd6 || E1 !== 1'b0 || E2 !== 1'b0 || E3 !== 1'b0 || E4 !== 1'b0) begin
      errors++;
      $display("FAIL result_frozen: got state=%0d E=%b%b%b%b want state=6 E=0000", state_o, E1, E2, E3, E4);
    end
  endtask
  task automatic test_result_exit;
    int n;
    ENTER = 1'b0;
    wait_change(3'd6, n);
    checks++;
    if (state_o !== 3'd0 || R1 !== 1'b1 || SEL !== 1'b0) begin
      errors++;
      $display("FAIL result_to_init: got state=%0d R1=%b SEL=%b want state=0 R1=1 SEL=0", state_o, R1, SEL);
    end
    step;
    checks++;
    if (state_o !== 3'd1 || E1 !== 1'b1) begin
      errors++;
      $display("FAIL init_to_setup: got state=%0d E1=%b want state=1 E1=1", state_o, E1);
    end
    ENTER = 1'b1;
    settle;
  endtask
  task automatic test_wrong_key;
    int n;
    go_user;
    match = 1'b0; end_User = 1'b1; win = 1'b0;
    ENTER = 1'b0;
    wait_change(3'd3, n);
    checks++;
    if (state_o !== 3'd4) begin
      errors++;
      $display("FAIL wrong_check: got state=%0d want 4", state_o);
    end
    step;
    checks++;
    if (state_o !== 3'd6 || SEL !== 1'b1) begin
      errors++;
      $display("FAIL wrong_result: got state=%0d SEL=%b want state=6 SEL=1", state_o, SEL);
    end
    ENTER = 1'b1;
    settle;
    match = 1'b1; end_User = 1'b0;
    test_result_exit;
  endtask
  task automatic test_user_loop;
    int n;
    go_user;
    match = 1'b1; end_User = 1'b0; win = 1'b1;
    ENTER = 1'b0;
    wait_change(3'd3, n);
    checks++;
    if (state_o !== 3'd4 || E4 !== 1'b1) begin
      errors++;
      $display("FAIL loop_check: got state=%0d E4=%b want state=4 E4=1", state_o, E4);
    end
    step;
    checks++;
    if (state_o !== 3'd3 || E2 !== 1'b1) begin
      errors++;
      $display("FAIL loop_back_user: got state=%0d E2=%b want state=3 E2=1", state_o, E2);
    end
    ENTER = 1'b1;
    settle;
    win = 1'b0;
    checks++;
    if (state_o !== 3'd3) begin
      errors++;
      $display("FAIL user_waits: got state=%0d want 3", state_o);
    end
  endtask
  task automatic test_advance;
    int n;
    match = 1'b1; end_User = 1'b1; win = 1'b0;
    ENTER = 1'b0;
    wait_change(3'd3, n);
    checks++;
    if (state_o !== 3'd4) begin
      errors++;
      $display("FAIL adv_check: got state=%0d want 4", state_o);
    end
    step;
    checks++;
    if (state_o !== 3'd5 || R2 !== 1'b1 || E4 !== 1'b1 || E3 !== 1'b0 || R1 !== 1'b0) begin
      errors++;
      $display("FAIL adv_next: got state=%0d R2=%b E4=%b E3=%b R1=%b want state=5 R2=1 E4=1 E3=0 R1=0", state_o, R2, E4, E3, R1);
    end
    step;
    checks++;
    if (state_o !== 3'd2 || E3 !== 1'b1 || E4 !== 1'b0) begin
      errors++;
      $display("FAIL adv_fpga: got state=%0d E3=%b E4=%b want state=2 E3=1 E4=0", state_o, E3, E4);
    end
    end_User = 1'b0;
    ENTER = 1'b1;
    settle;
    end_FPGA = 1'b1;
    step;
    end_FPGA = 1'b0;
    checks++;
    if (state_o !== 3'd3) begin
      errors++;
      $display("FAIL adv_user: got state=%0d want 3", state_o);
    end
  endtask
  task automatic test_timeout;
    ENTER = 1'b0;
    repeat (LAT - 1) step;
    checks++;
    if (state_o !== 3'd3) begin
      errors++;
      $display("FAIL enter_latency: got state=%0d want 3", state_o);
    end
    end_time = 1'b1;
    step;
    end_time = 1'b0;
    checks++;
    if (state_o !== 3'd6 || SEL !== 1'b1) begin
      errors++;
      $display("FAIL timeout_priority: got state=%0d SEL=%b want state=6 SEL=1", state_o, SEL);
    end
    repeat (100) step;
    checks++;
    if (state_o !== 3'd6) begin
      errors++;
      $display("FAIL held_single_pulse: got state=%0d want 6", state_o);
    end
    ENTER = 1'b1;
    settle;
    checks++;
    if (state_o !== 3'd6) begin
      errors++;
      $display("FAIL release_no_pulse: got state=%0d want 6", state_o);
    end
  endtask
  task automatic test_async_reset;
    restart;
    go_user;
    @(posedge CLOCK_50);
    #2;
    RESET_N = 1'b0;
    #1;
    checks++;
    if (state_o !== 3'd0 || R1 !== 1'b1 || R2 !== 1'b1 || SEL !== 1'b0 || E2 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got state=%0d R1=%b R2=%b SEL=%b E2=%b want state=0 R1=1 R2=1 SEL=0 E2=0", state_o, R1, R2, SEL, E2);
    end
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    step;
    checks++;
    if (state_o !== 3'd1 || E1 !== 1'b1) begin
      errors++;
      $display("FAIL async_release: got state=%0d E1=%b want state=1 E1=1", state_o, E1);
    end
  endtask
`ifdef GENIUS_DEBOUNCE_EN
  task automatic test_debounce;
    int n;
    ENTER = 1'b0;
    repeat (5) step;
    ENTER = 1'b1;
    repeat (30) step;
    checks++;
    if (state_o !== 3'd1) begin
      errors++;
      $display("FAIL glitch_rejected: got state=%0d want 1", state_o);
    end
    ENTER = 1'b0;
    wait_change(3'd1, n);
    repeat (20 - n) step;
    ENTER = 1'b1;
    checks++;
    if (state_o !== 3'd2) begin
      errors++;
      $display("FAIL debounced_press: got state=%0d want 2", state_o);
    end
    checks++;
    if (n < 11 || n > 13) begin
      errors++;
      $display("FAIL debounce_latency: got %0d cycles want 11..13", n);
    end
    settle;
  endtask
`endif
  initial begin
    test_reset;
    test_ignore;
    test_win;
    test_result_exit;
    test_wrong_key;
    test_user_loop;
    test_advance;
    test_timeout;
    test_async_reset;
`ifdef GENIUS_DEBOUNCE_EN
    test_debounce;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end
endmodule

// File: doc/genius_control.md
Name: genius_control

Overview:
- Main FSM of the Genius memory game.
- Sequences the game datapath by driving its reset lines (R1, R2), enable lines (E1–E4) and display select (SEL).
- Reacts to the datapath status flags (end_FPGA, end_User, end_time, win, match) and to a player ENTER pushbutton.
- Sits beside the datapath at the top level, which ties the two together.

Parameters:
- p_state, 3, state register / debug output width.
- p_sync, 2, number of synchronizer flops on ENTER.
- p_debounce, 20, debounce counter width (only used with GENIUS_DEBOUNCE_EN).
- DEBOUNCE_CYCLES, 1000000, stable cycles required before ENTER is accepted (20 ms at 50 MHz).

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- RESET_N  input  1  asynchronous, active-low reset.
- ENTER  input  1  player confirm pushbutton, active-low, asynchronous to the clock.
- end_FPGA  input  1  datapath has finished displaying the current sequence.
- end_User  input  1  player has entered the full sequence for this round.
- end_time  input  1  player entry timer expired.
- win  input  1  final round completed.
- match  input  1  last user entry equals the expected symbol.
- R1  output  1  reset of game registers (round, points, sequence).
- R2  output  1  reset of entry timer and user counter.
- E1  output  1  load setup configuration from SWITCH.
- E2  output  1  entry timer count enable.
- E3  output  1  FPGA sequence display counter enable.
- E4  output  1  user entry capture / round advance enable.
- SEL  output  1  display select: 0 = play view, 1 = result view.
- state_o  output  p_state  current state code, for debug.

Behaviour:
- Reset: RESET_N low immediately forces state to S_INIT; the state register is updated asynchronously. Resetting mid-game aborts the game with no partial outputs retained.
- Output style: all control outputs are a Moore decode of the state register. Any output not listed for a state is 0.
- ENTER path: inverted, passed through p_sync flops, then a rising-edge detect produces enter_p, a one-cycle pulse.
  - A press reaches enter_p 3 clocks after the synchronized edge.
  - A held key produces exactly one pulse.
  - enter_p is ignored in every state that does not consume it.
- State encoding:
  - 0 = S_INIT
  - 1 = S_SETUP
  - 2 = S_FPGA
  - 3 = S_USER
  - 4 = S_CHECK
  - 5 = S_NEXT
  - 6 = S_RESULT
  - Codes 7 and above are illegal and go to S_INIT on the next clock.
- S_INIT:
  - Outputs R1=1, R2=1, SEL=0.
  - Goes to S_SETUP unconditionally after 1 cycle.
- S_SETUP:
  - Outputs E1=1.
  - Goes to S_FPGA on enter_p.
- S_FPGA:
  - Outputs E3=1, R2=1.
  - Goes to S_USER when end_FPGA=1.
- S_USER:
  - Outputs E2=1.
  - Exit conditions, in priority order:
    1. end_time=1 goes to S_RESULT. Timeout wins over a same-cycle enter_p.
    2. enter_p goes to S_CHECK.
- S_CHECK (one cycle, outputs E4=1). Next state, in priority order:
  1. match=0 goes to S_RESULT.
  2. end_User=1 and win=1 goes to S_RESULT.
  3. end_User=1 and win=0 goes to S_NEXT.
  4. Otherwise goes back to S_USER.
- S_NEXT:
  - One cycle, outputs R2=1, E4=1.
  - Goes to S_FPGA.
- S_RESULT:
  - Outputs SEL=1; all enables are 0, so the score is frozen.
  - Goes to S_INIT on enter_p.
- Status flags are sampled only in the states named above. Flags asserted in any other state have no effect.
- Exactly one next-state decision is made per clock. There are no combinational loops from status inputs to R/E outputs.

Optional Feature:
- Macro: GENIUS_DEBOUNCE_EN.
- Defined:
  - A p_debounce-bit counter follows the synchronized ENTER level.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive equal samples.
  - Edge detection operates on the debounced level, so bounces shorter than that count produce no pulse.
  - Counter resets to 0 and debounced level resets to 0 (released).
- Undefined:
  - The edge detect operates directly on the synchronizer output.
  - No counter is instantiated.

Decomposition:
- Shared package genius_pkg holds:
  - the state typedef and encodings S_INIT..S_RESULT;
  - p_state;
  - the DEBOUNCE_CYCLES default.
- One sub-module, key_pulse: synchronizer, optional debounce and rising-edge pulse generator. It is reusable for other KEY inputs.

Test Plan:
- Reset and setup: assert RESET_N=0 mid S_USER → state_o=0, R1=R2=1, SEL=0 with no clock. Release → next clock state_o=1, E1=1.
- Single round, win:
  - Stimulus: ENTER press → S_FPGA (E3=1). Pulse end_FPGA → S_USER (E2=1). ENTER with match=1, end_User=1, win=1.
  - Required: exactly one S_CHECK cycle with E4=1, then S_RESULT with SEL=1.
- Advance round: in S_CHECK with match=1, end_User=1, win=0 → S_NEXT for 1 cycle (R2=1, E4=1), then S_FPGA.
- Wrong key: in S_CHECK with match=0 → S_RESULT. A further ENTER returns to S_INIT, then S_SETUP.
- Timeout collision: in S_USER, end_time=1 in the same cycle as enter_p → S_RESULT, never S_CHECK. ENTER held low for 100 cycles yields exactly one enter_p.
- Debounce (with GENIUS_DEBOUNCE_EN, DEBOUNCE_CYCLES=8): 5-cycle glitch → no transition. 20-cycle press → one transition, occurring 8+3 cycles after the edge.
